// File: rtl/cfeb_sync_pkg.sv
// Shared definitions for CFEB fiber link synchronisation: state encoding and
// the K-characters used as frame separators and FC markers.
package cfeb_sync_pkg;

   typedef enum logic [1:0] {
      ST_DISABLED    = 2'd0,
      ST_HUNT        = 2'd1,
      ST_LOCKED      = 2'd2,
      ST_RESYNC_WAIT = 2'd3
   } link_state_t;

   localparam logic [7:0] K_IDLE = 8'hBC;
   localparam logic [7:0] K_MARK = 8'hFC;

   function automatic logic is_clean_frame(input logic strobe, input logic [7:0] kchar,
                                           input logic err);
      return strobe && ((kchar == K_IDLE) || (kchar == K_MARK)) && !err;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter with programmable increment that sticks at all-ones instead of
// wrapping; clear is synchronous and wins over increment.
module sat_counter #(
   parameter int WIDTH = 16,
   parameter int INC   = 1
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             inc_en,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH:0] sum;

   assign sum = {1'b0, count} + (WIDTH+1)'(INC);

   always_ff @(posedge clock) begin
      if (clear)
         count <= '0;
      else if (inc_en)
         count <= sum[WIDTH] ? {WIDTH{1'b1}} : sum[WIDTH-1:0];
   end

endmodule

// File: rtl/cfeb_link_sync.sv
// Per-fiber CFEB link alignment: hunts for clean frames, tracks FC markers
// after a TTC resync, and accumulates bad-frame / marker errors.
module cfeb_link_sync
   import cfeb_sync_pkg::*;
#(
   parameter int GOOD_FRAMES   = 32,
   parameter int BAD_FRAMES    = 4,
   parameter int MARKER_PERIOD = 128
) (
   input  logic        clock,
   input  logic        global_reset,
   input  logic        ttc_resync,
   input  logic        fiber_enable,
   input  logic        rx_pll_lock,
   input  logic        rx_frame_strobe,
   input  logic [7:0]  rx_kchar,
   input  logic        rx_err,
   output logic        link_good,
   output logic        sync_done,
   output logic [7:0]  kchar_out,
   output logic        marker_err,
   output logic [15:0] err_count,
   output link_state_t state_dbg
);

   localparam int GW = $clog2(GOOD_FRAMES + 1);
   localparam int BW = $clog2(BAD_FRAMES + 1);
   localparam int FW = (MARKER_PERIOD > 1) ? $clog2(MARKER_PERIOD) : 1;
   localparam logic [GW-1:0] GOOD_LAST  = GW'(GOOD_FRAMES - 1);
   localparam logic [BW-1:0] BAD_LAST   = BW'(BAD_FRAMES - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(MARKER_PERIOD - 1);

   link_state_t   state_q, state_d;
   logic [GW-1:0] good_q, good_d;
   logic [BW-1:0] bad_q, bad_d;
   logic [FW-1:0] frame_q, frame_d;
   logic          merr_d, bad_frame, frame_clean, is_mark;

   assign frame_clean = is_clean_frame(rx_frame_strobe, rx_kchar, rx_err);
   assign is_mark     = (rx_kchar == K_MARK);
   assign state_dbg   = state_q;

   always_comb begin
      state_d   = state_q;
      good_d    = good_q;
      bad_d     = bad_q;
      frame_d   = frame_q;
      merr_d    = 1'b0;
      bad_frame = 1'b0;
      if (!fiber_enable) begin
         state_d = ST_DISABLED;
         good_d  = '0;
         bad_d   = '0;
         frame_d = '0;
      end else if ((state_q == ST_DISABLED) || !rx_pll_lock) begin
         state_d = ST_HUNT;
         good_d  = '0;
         bad_d   = '0;
         frame_d = '0;
      end else begin
         bad_frame = rx_frame_strobe && !frame_clean;
         case (state_q)
            ST_HUNT: begin
               if (frame_clean) begin
                  if (good_q == GOOD_LAST) begin
                     state_d = ST_RESYNC_WAIT;
                     good_d  = '0;
                     bad_d   = '0;
                  end else begin
                     good_d = good_q + GW'(1);
                  end
               end else if (rx_frame_strobe) begin
                  good_d = '0;
               end
            end
            ST_LOCKED, ST_RESYNC_WAIT: begin
               if (rx_frame_strobe)
                  bad_d = frame_clean ? '0 : bad_q + BW'(1);
               // A resync in the same cycle as a frame skips marker checking for it.
               if (state_q == ST_LOCKED) begin
                  if (ttc_resync) begin
                     state_d = ST_RESYNC_WAIT;
                  end else if (rx_frame_strobe) begin
                     if (frame_q == FRAME_LAST) begin
                        merr_d  = !is_mark;
                        frame_d = '0;
                     end else if (is_mark) begin
                        merr_d  = 1'b1;
                        frame_d = '0;
                     end else begin
                        frame_d = frame_q + FW'(1);
                     end
                  end
               end else if (!ttc_resync && frame_clean && is_mark) begin
                  state_d = ST_LOCKED;
                  frame_d = '0;
               end
               if (bad_frame && (bad_q == BAD_LAST)) begin
                  state_d = ST_HUNT;
                  good_d  = '0;
                  bad_d   = '0;
                  frame_d = '0;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (global_reset) begin
         state_q    <= fiber_enable ? ST_HUNT : ST_DISABLED;
         good_q     <= '0;
         bad_q      <= '0;
         frame_q    <= '0;
         link_good  <= 1'b0;
         sync_done  <= !fiber_enable;
         kchar_out  <= 8'h00;
         marker_err <= 1'b0;
      end else begin
         state_q    <= state_d;
         good_q     <= good_d;
         bad_q      <= bad_d;
         frame_q    <= frame_d;
         link_good  <= (state_d == ST_LOCKED) || (state_d == ST_RESYNC_WAIT);
         sync_done  <= (state_d == ST_DISABLED) || (state_d == ST_LOCKED);
         marker_err <= merr_d;
         if (rx_frame_strobe)
            kchar_out <= rx_kchar;
      end
   end

   sat_counter #(.WIDTH(16), .INC(1)) u_err_count (
      .clock  (clock),
      .clear  (global_reset || !fiber_enable),
      .inc_en (bad_frame || merr_d),
      .count  (err_count)
   );

endmodule

// File: tb/tb_cfeb_link_sync.sv
// Directed bench for cfeb_link_sync: lock acquisition, FC marker tracking,
// resync handling, bad-frame loss of lock, PLL loss, reset and disable.
module tb_cfeb_link_sync;
   import cfeb_sync_pkg::*;

   logic        clock = 1'b0;
   logic        global_reset = 1'b1;
   logic        ttc_resync = 1'b0;
   logic        fiber_enable = 1'b1;
   logic        rx_pll_lock = 1'b1;
   logic        rx_frame_strobe = 1'b0;
   logic [7:0]  rx_kchar = 8'h00;
   logic        rx_err = 1'b0;
   logic        link_good, sync_done, marker_err;
   logic [7:0]  kchar_out;
   logic [15:0] err_count;
   link_state_t state_dbg;

   int   checks = 0;
   int   errors = 0;
   logic merr_cap;
   logic merr_seen;

   always #5 clock = ~clock;

   cfeb_link_sync dut (
      .clock           (clock),
      .global_reset    (global_reset),
      .ttc_resync      (ttc_resync),
      .fiber_enable    (fiber_enable),
      .rx_pll_lock     (rx_pll_lock),
      .rx_frame_strobe (rx_frame_strobe),
      .rx_kchar        (rx_kchar),
      .rx_err          (rx_err),
      .link_good       (link_good),
      .sync_done       (sync_done),
      .kchar_out       (kchar_out),
      .marker_err      (marker_err),
      .err_count       (err_count),
      .state_dbg       (state_dbg)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One frame occupies two clocks; marker_err is captured one clock after the strobe.
   task automatic send_frame(input logic [7:0] k, input logic e);
      rx_frame_strobe = 1'b1;
      rx_kchar        = k;
      rx_err          = e;
      @(posedge clock); #1;
      merr_cap        = marker_err;
      rx_frame_strobe = 1'b0;
      ttc_resync      = 1'b0;
      rx_err          = 1'b0;
      @(posedge clock); #1;
   endtask

   task automatic send_idles(input int n);
      merr_seen = 1'b0;
      for (int i = 0; i < n; i++) begin
         send_frame(K_IDLE, 1'b0);
         merr_seen = merr_seen | merr_cap;
      end
   endtask

   initial begin
      // Reset state
      @(posedge clock); @(posedge clock); #1;
      check("rst_state", state_dbg, ST_HUNT);
      check("rst_link_good", link_good, 0);
      check("rst_sync_done", sync_done, 0);
      check("rst_kchar", kchar_out, 0);
      check("rst_marker_err", marker_err, 0);
      check("rst_err_count", err_count, 0);
      global_reset = 1'b0;

      // Acquisition: 31 clean frames not enough, the 32nd locks
      send_idles(31);
      check("hunt31_link_good", link_good, 0);
      send_frame(K_IDLE, 1'b0);
      check("hunt32_link_good", link_good, 1);
      check("hunt32_sync_done", sync_done, 0);
      check("hunt32_state", state_dbg, ST_RESYNC_WAIT);
      check("hunt32_kchar", kchar_out, 8'hBC);

      // First FC completes the sync
      send_frame(K_MARK, 1'b0);
      check("fc_sync_done", sync_done, 1);
      check("fc_state", state_dbg, ST_LOCKED);
      check("fc_kchar", kchar_out, 8'hFC);

      // 1000 frames with FC every 128th
      merr_seen = 1'b0;
      for (int i = 1; i <= 1000; i++) begin
         send_frame((i % 128 == 0) ? K_MARK : K_IDLE, 1'b0);
         merr_seen = merr_seen | merr_cap;
      end
      check("period_no_merr", merr_seen, 0);
      check("period_err_count", err_count, 0);
      check("period_sync_done", sync_done, 1);

      // Resync coincident with FC: the FC does not complete it
      ttc_resync = 1'b1;
      send_frame(K_MARK, 1'b0);
      check("rsync_sync_done", sync_done, 0);
      check("rsync_state", state_dbg, ST_RESYNC_WAIT);
      check("rsync_link_good", link_good, 1);
      check("rsync_merr", merr_cap, 0);
      send_frame(K_MARK, 1'b0);
      check("rsync_fc_sync_done", sync_done, 1);
      check("rsync_fc_state", state_dbg, ST_LOCKED);

      // Misplaced FC at frame_cnt=100
      send_idles(100);
      check("pre_misplaced_merr", merr_seen, 0);
      send_frame(K_MARK, 1'b0);
      check("misplaced_merr", merr_cap, 1);
      check("misplaced_merr_one_cycle", marker_err, 0);
      check("misplaced_err_count", err_count, 1);
      send_idles(127);
      check("realign_idle_merr", merr_seen, 0);
      send_frame(K_MARK, 1'b0);
      check("realign_fc_merr", merr_cap, 0);
      check("realign_err_count", err_count, 1);

      // Missing FC at frame_cnt=127
      send_idles(127);
      check("pre_missing_merr", merr_seen, 0);
      send_frame(K_IDLE, 1'b0);
      check("missing_merr", merr_cap, 1);
      check("missing_err_count", err_count, 2);

      // Bad-frame bursts: 3 bad, 1 clean, 4 bad
      send_frame(K_IDLE, 1'b1);
      send_frame(8'h55, 1'b0);
      send_frame(K_IDLE, 1'b1);
      check("burst1_link_good", link_good, 1);
      check("burst1_err_count", err_count, 5);
      send_frame(K_IDLE, 1'b0);
      send_frame(K_IDLE, 1'b1);
      send_frame(K_IDLE, 1'b1);
      send_frame(K_IDLE, 1'b1);
      check("burst2_3_link_good", link_good, 1);
      check("burst2_3_state", state_dbg, ST_LOCKED);
      send_frame(K_IDLE, 1'b1);
      check("burst2_4_link_good", link_good, 0);
      check("burst2_4_state", state_dbg, ST_HUNT);
      check("burst2_err_count", err_count, 9);

      // PLL loss drops the link
      send_idles(32);
      check("relock_link_good", link_good, 1);
      rx_pll_lock = 1'b0;
      @(posedge clock); #1;
      check("pll_state", state_dbg, ST_HUNT);
      check("pll_link_good", link_good, 0);
      check("pll_sync_done", sync_done, 0);
      rx_pll_lock = 1'b1;

      // Reset mid-lock, then relock from zero
      send_idles(32);
      send_frame(K_MARK, 1'b0);
      check("lock2_state", state_dbg, ST_LOCKED);
      check("lock2_err_count", err_count, 9);
      global_reset = 1'b1;
      @(posedge clock); #1;
      global_reset = 1'b0;
      check("mrst_state", state_dbg, ST_HUNT);
      check("mrst_link_good", link_good, 0);
      check("mrst_sync_done", sync_done, 0);
      check("mrst_kchar", kchar_out, 0);
      check("mrst_err_count", err_count, 0);
      send_idles(31);
      check("mrst_hunt31", link_good, 0);
      send_frame(K_IDLE, 1'b0);
      check("mrst_hunt32", link_good, 1);

      // Fiber disabled
      fiber_enable = 1'b0;
      @(posedge clock); #1;
      check("dis_state", state_dbg, ST_DISABLED);
      check("dis_sync_done", sync_done, 1);
      check("dis_link_good", link_good, 0);
      ttc_resync = 1'b1;
      @(posedge clock); #1;
      ttc_resync = 1'b0;
      check("dis_resync_state", state_dbg, ST_DISABLED);
      fiber_enable = 1'b1;
      @(posedge clock); #1;
      check("en_state", state_dbg, ST_HUNT);
      check("en_sync_done", sync_done, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
